// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the data-memory access unit:
// access sizes, FSM states, byte-lane masks and store-data replication.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Byte offset actually used for an access: narrower sizes keep their lane,
    // half and word accesses are silently forced onto their natural boundary.
    function automatic logic [1:0] lane_offset(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return off;
            SZ_HALF: return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_mask(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return MASK_BYTE << off;
            SZ_HALF: return MASK_HALF << {off[1], 1'b0};
            default: return MASK_WORD;
        endcase
    endfunction

    function automatic logic [31:0] replicate_wdata(input size_e sz, input logic [31:0] w);
        case (sz)
            SZ_BYTE: return {4{w[7:0]}};
            SZ_HALF: return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    // The reserved size is treated as misaligned regardless of address.
    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return (off != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response handshake plus data-memory port of the
// access unit; slave is the unit, master is the pipeline/memory environment.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wea;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_wea
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_wea
    );
endinterface

// File: rtl/mem_load_align.sv
// Load-data extraction: shifts the addressed lane down, truncates to the
// access size and sign- or zero-extends; word loads pass straight through.
module mem_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  size_e       size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted_s;

    // Lane shift followed by size truncation and extension.
    always_comb begin
        shifted_s = rdata_i >> {offset_i, 3'b000};
        case (size_i)
            SZ_BYTE: data_o = {{24{signed_i & shifted_s[7]}}, shifted_s[7:0]};
            SZ_HALF: data_o = {{16{signed_i & shifted_s[15]}}, shifted_s[15:0]};
            default: data_o = shifted_s;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: turns MEM-stage load/store requests into aligned memory
// accesses. Optional misalignment trapping is enabled by defining MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 0
) (
    input  logic              clk,
    input  logic              resetn,
    mem_access_unit_if.slave  bus
);

    localparam logic [1:0] WAIT_INIT = 2'(MEM_LATENCY - 1);

    state_e      state_q;
    logic        we_q;
    size_e       size_q;
    logic        signed_q;
    logic [1:0]  off_q;
    logic [1:0]  cnt_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wea_q;

    size_e       req_size_d;
    logic        trap_d;
    logic [3:0]  mask_d;
    logic [31:0] wdata_d;
    logic [31:0] load_data_s;

    assign req_size_d = size_e'(bus.req_size);
    assign mask_d     = byte_mask(req_size_d, bus.req_addr[1:0]);
    assign wdata_d    = replicate_wdata(req_size_d, bus.req_wdata);

`ifdef MISALIGN_TRAP_EN
    assign trap_d = is_misaligned(req_size_d, bus.req_addr[1:0]);
`else
    assign trap_d = 1'b0;
`endif

    mem_load_align u_align (
        .rdata_i  (bus.mem_rdata),
        .offset_i (lane_offset(size_q, off_q)),
        .size_i   (size_q),
        .signed_i (signed_q),
        .data_o   (load_data_s)
    );

    // Access FSM; every bus-facing output is a register updated here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            off_q        <= 2'b00;
            cnt_q        <= 2'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
            mem_wea_q    <= MASK_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        size_q      <= req_size_d;
                        signed_q    <= bus.req_signed;
                        off_q       <= bus.req_addr[1:0];
                        req_ready_q <= 1'b0;
                        if (trap_d) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0000_0000;
                        end else begin
                            state_q     <= ST_ACCESS;
                            mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                            mem_wdata_q <= wdata_d;
                            mem_wea_q   <= bus.req_we ? mask_d : MASK_NONE;
                        end
                    end
                end
                ST_ACCESS: begin
                    mem_wea_q <= MASK_NONE;
                    if (we_q) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'h0000_0000;
                    end else if (MEM_LATENCY == 0) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_data_s;
                    end else begin
                        state_q <= ST_WAIT;
                        cnt_q   <= WAIT_INIT;
                    end
                end
                ST_WAIT: begin
                    mem_wea_q <= MASK_NONE;
                    if (cnt_q == 2'd0) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_data_s;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ST_RESP: begin
                    mem_wea_q <= MASK_NONE;
                    if (bus.resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    mem_wea_q    <= MASK_NONE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wea    = mem_wea_q;
`ifdef MISALIGN_TRAP_EN
    assign bus.resp_err   = resp_err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance at MEM_LATENCY 0 and one at 2.
// Covers the misaligned path in both MISALIGN_TRAP_EN builds.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk;
    logic resetn;
    int   tests;
    int   fails;

    mem_access_unit_if if0 ();
    mem_access_unit_if if2 ();

    mem_access_unit #(.MEM_LATENCY(0)) dut0 (.clk(clk), .resetn(resetn), .bus(if0));
    mem_access_unit #(.MEM_LATENCY(2)) dut2 (.clk(clk), .resetn(resetn), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        resetn = 1'b0;
        if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_size = 2'd0; if0.req_signed = 1'b0;
        if0.req_addr = 32'h0; if0.req_wdata = 32'h0; if0.resp_ready = 1'b0; if0.mem_rdata = 32'h0;
        if2.req_valid = 1'b0; if2.req_we = 1'b0; if2.req_size = 2'd0; if2.req_signed = 1'b0;
        if2.req_addr = 32'h0; if2.req_wdata = 32'h0; if2.resp_ready = 1'b0; if2.mem_rdata = 32'h0;

        tick(); tick();
        chk("rst_req_ready", 32'(if0.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(if0.resp_valid), 32'd0);
        chk("rst_resp_err", 32'(if0.resp_err), 32'd0);
        chk("rst_mem_wea", 32'(if0.mem_wea), 32'd0);
        chk("rst_mem_addr", if0.mem_addr, 32'h0);
        chk("rst_mem_wdata", if0.mem_wdata, 32'h0);
        chk("rst_resp_rdata", if0.resp_rdata, 32'h0);
        resetn = 1'b1;
        tick();

        // Store byte at 0x13
        if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_size = 2'd0;
        if0.req_addr = 32'h0000_0013; if0.req_wdata = 32'h0000_00AB;
        tick();
        if0.req_valid = 1'b0;
        chk("sb_wea", 32'(if0.mem_wea), 32'b1000);
        chk("sb_addr", if0.mem_addr, 32'h0000_0010);
        chk("sb_wdata", if0.mem_wdata, 32'hABAB_ABAB);
        chk("sb_req_ready_busy", 32'(if0.req_ready), 32'd0);
        chk("sb_resp_early", 32'(if0.resp_valid), 32'd0);
        if0.resp_ready = 1'b1;
        tick();
        chk("sb_wea_one_cycle", 32'(if0.mem_wea), 32'd0);
        chk("sb_resp_valid", 32'(if0.resp_valid), 32'd1);
        chk("sb_resp_rdata", if0.resp_rdata, 32'h0);
        tick();
        chk("sb_back_idle", 32'(if0.req_ready), 32'd1);
        chk("sb_resp_drop", 32'(if0.resp_valid), 32'd0);

        // Signed half load at 0x22, response held for five cycles
        if0.resp_ready = 1'b0;
        if0.mem_rdata = 32'h8001_1234;
        if0.req_valid = 1'b1; if0.req_we = 1'b0; if0.req_size = 2'd1;
        if0.req_signed = 1'b1; if0.req_addr = 32'h0000_0022;
        tick();
        chk("lh_addr", if0.mem_addr, 32'h0000_0020);
        chk("lh_wea", 32'(if0.mem_wea), 32'd0);
        if0.req_signed = 1'b0;
        tick();
        chk("lh_resp_valid", 32'(if0.resp_valid), 32'd1);
        chk("lh_signed", if0.resp_rdata, 32'hFFFF_8001);
        if0.mem_rdata = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 32'(if0.resp_valid), 32'd1);
            chk("hold_rdata", if0.resp_rdata, 32'hFFFF_8001);
            chk("hold_no_accept", 32'(if0.req_ready), 32'd0);
        end
        if0.mem_rdata = 32'h8001_1234;
        if0.resp_ready = 1'b1;
        tick();
        chk("release_idle", 32'(if0.req_ready), 32'd1);
        chk("release_valid", 32'(if0.resp_valid), 32'd0);
        tick();
        if0.req_valid = 1'b0;
        chk("lhu_accept", 32'(if0.req_ready), 32'd0);
        tick();
        chk("lh_unsigned", if0.resp_rdata, 32'h0000_8001);
        tick();

        // Signed byte load from the top lane
        if0.req_valid = 1'b1; if0.req_size = 2'd0; if0.req_signed = 1'b1;
        if0.req_addr = 32'h0000_0023;
        tick();
        if0.req_valid = 1'b0;
        tick();
        chk("lb_signed", if0.resp_rdata, 32'hFFFF_FF80);
        tick();

        // Misaligned word store at 0x41
        if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_size = 2'd2;
        if0.req_addr = 32'h0000_0041; if0.req_wdata = 32'hCAFE_F00D;
        tick();
        if0.req_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
        chk("trap_wea", 32'(if0.mem_wea), 32'd0);
        chk("trap_resp_valid", 32'(if0.resp_valid), 32'd1);
        chk("trap_err", 32'(if0.resp_err), 32'd1);
        chk("trap_rdata", if0.resp_rdata, 32'h0);
        tick();
        chk("trap_idle", 32'(if0.req_ready), 32'd1);
`else
        chk("mis_wea", 32'(if0.mem_wea), 32'b1111);
        chk("mis_addr", if0.mem_addr, 32'h0000_0040);
        chk("mis_wdata", if0.mem_wdata, 32'hCAFE_F00D);
        tick();
        chk("mis_resp_valid", 32'(if0.resp_valid), 32'd1);
        chk("mis_err", 32'(if0.resp_err), 32'd0);
        tick();
`endif

        // Reset during the ACCESS cycle of a store
        if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_size = 2'd2;
        if0.req_addr = 32'h0000_0008; if0.req_wdata = 32'h1234_5678;
        tick();
        if0.req_valid = 1'b0;
        chk("rs_wea_pre", 32'(if0.mem_wea), 32'b1111);
        #2 resetn = 1'b0;
        #1;
        chk("rs_wea", 32'(if0.mem_wea), 32'd0);
        chk("rs_req_ready", 32'(if0.req_ready), 32'd1);
        chk("rs_addr", if0.mem_addr, 32'h0);
        chk("rs_wdata", if0.mem_wdata, 32'h0);
        chk("rs_resp_valid", 32'(if0.resp_valid), 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        chk("rs_still_idle", 32'(if0.resp_valid), 32'd0);
        chk("rs_no_write", 32'(if0.mem_wea), 32'd0);

        // MEM_LATENCY=2 word load at 0x40
        if2.resp_ready = 1'b1;
        if2.mem_rdata = 32'h1111_1111;
        if2.req_valid = 1'b1; if2.req_we = 1'b0; if2.req_size = 2'd2;
        if2.req_signed = 1'b1; if2.req_addr = 32'h0000_0040;
        tick();
        if2.req_valid = 1'b0;
        chk("l2_addr", if2.mem_addr, 32'h0000_0040);
        chk("l2_busy0", 32'(if2.req_ready), 32'd0);
        tick();
        chk("l2_wait1", 32'(if2.resp_valid), 32'd0);
        chk("l2_busy1", 32'(if2.req_ready), 32'd0);
        tick();
        chk("l2_wait2", 32'(if2.resp_valid), 32'd0);
        chk("l2_busy2", 32'(if2.req_ready), 32'd0);
        chk("l2_addr_hold", if2.mem_addr, 32'h0000_0040);
        if2.mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("l2_resp_valid", 32'(if2.resp_valid), 32'd1);
        chk("l2_rdata", if2.resp_rdata, 32'hDEAD_BEEF);
        chk("l2_busy3", 32'(if2.req_ready), 32'd0);
        tick();
        chk("l2_idle", 32'(if2.req_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory port: converts CPU MEM-stage load/store requests into word-aligned address, replicated write data, byte write-enables, and aligned/extended load results.
- Sits between the pipeline MEM stage and the data-memory block.
- That memory has a synchronous write with a 4-bit byte enable and a read latency given by MEM_LATENCY.
- Valid/ready handshake on both sides, so the pipeline stalls while an access is in flight.

Parameters:
- MEM_LATENCY, 0: cycles between presenting the address and read data being valid (0 = combinational-read distributed RAM, 1 = block RAM); legal range 0..3.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_signed  in  1  sign-extend a load result.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  result/completion available.
- resp_ready  in  1  pipeline consumes the response.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  misaligned access (only with MISALIGN_TRAP_EN; otherwise tied 0).
- mem_addr  out  32  word address, {addr[31:2], 2'b00}.
- mem_wdata  out  32  replicated store data.
- mem_wea  out  4  byte write enables.
- mem_rdata  in  32  memory read data.

Behaviour:
- Reset is asynchronous and active-low: resetn low forces state IDLE. Reset values:
  - req_ready = 1.
  - resp_valid, resp_err, mem_wea = 0.
  - resp_rdata, mem_addr, mem_wdata = 0.
  - Wait counter = 0.
- Reset mid-access drops the access. A write that is reset in ACCESS is suppressed because mem_wea is forced to 0 asynchronously.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture we/size/signed/addr/wdata into registers and go to ACCESS.
- ACCESS (one cycle):
  - mem_addr and mem_wdata come from the captured registers.
  - Store: mem_wea = byte mask for this cycle only, then RESP.
  - Load with MEM_LATENCY = 0: sample mem_rdata this cycle, then RESP.
  - Load with MEM_LATENCY > 0: load counter with MEM_LATENCY-1, then WAIT.
- WAIT:
  - Hold mem_addr; mem_wea = 0.
  - Decrement the counter each cycle.
  - When counter = 0, sample mem_rdata and go to RESP.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err stay stable until resp_ready.
  - On resp_ready, go to IDLE.
  - req_ready = 0 in RESP, so there is no back-to-back overlap.
- req_ready = 0 in every state except IDLE.
- mem_wea = 0 in every state except ACCESS with a store.
- Latency from the accept edge: resp_valid rises 2 cycles later for stores and for loads at MEM_LATENCY = 0, or 2+MEM_LATENCY cycles later for loads otherwise.
- Byte mask:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << {addr[1], 1'b0}.
  - word or reserved: 4'b1111.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load extract:
  - Shift mem_rdata right by addr[1:0]*8.
  - Truncate to the access size.
  - Sign-extend if req_signed, else zero-extend.
  - Word ignores req_signed.
- Misalignment without the macro: half ignores addr[0], word ignores addr[1:0], so the access is silently aligned.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Half with addr[0] = 1, or word/reserved with addr[1:0] != 0, skips ACCESS/WAIT and goes IDLE→RESP directly.
  - mem_wea stays 0, resp_err = 1, resp_rdata = 0.
  - Resp latency 1 cycle.
  - Size 3 always traps.
- MISALIGN_TRAP_EN undefined: resp_err tied to 0 and the silent alignment above applies.

Decomposition:
- Shared package holds:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state encodings.
  - Mask and replicate constants.
- One natural combinational sub-module, mem_load_align: takes rdata, offset, size, signed and returns the extended data. The FSM, counter and registers stay in the top.

Test Plan:
- Store byte, addr 0x0000_0013, wdata 0x0000_00AB → one cycle of mem_wea = 4'b1000, mem_addr 0x10, mem_wdata 0xABABABAB; resp_valid 2 cycles after accept.
- Load half, signed, addr 0x22, mem_rdata 0x8001_1234 → resp_rdata 0xFFFF_8001; the same access unsigned → 0x0000_8001.
- MEM_LATENCY = 2: load word at 0x40, mem_rdata changes to 0xDEAD_BEEF after 2 cycles → resp_valid 4 cycles after accept with 0xDEAD_BEEF; req_ready low throughout.
- Hold resp_ready low for 5 cycles in RESP → resp_valid and resp_rdata stable, no new request accepted; release → IDLE next cycle.
- Assert resetn low during ACCESS of a store → mem_wea 0 immediately, outputs at reset values, memory unchanged.
- With MISALIGN_TRAP_EN: store word at 0x41 → mem_wea never asserted, resp_err = 1 one cycle after accept.
